// File: rtl/game_pkg.sv
// Shared move encodings and sizing for the move-history (undo) block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package game_pkg;

    // Default history depth matches the step counter modulus.
    localparam int GAME_DEPTH    = 255;
    localparam int GAME_PTR_BITS = 8;

    // One history entry is {dir[1:0], push}.
    localparam int ENTRY_W = 3;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef struct packed {
        dir_t dir;
        logic push;
    } move_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        PRESENT = 2'd2
    } hist_state_t;

endpackage

// File: rtl/game_history_ram.sv
// Simple dual-port history storage, one write port and one read port, no reset.
// Latency: write lands on the clock edge; read data valid the cycle after re.
// Backpressure: none; read data holds until the next re.
module game_history_ram #(
    parameter int DEPTH    = 255,
    parameter int AddrBits = 8,
    parameter int Width    = 3
) (
    input  logic                clk,
    input  logic                we,
    input  logic [AddrBits-1:0] waddr,
    input  logic [Width-1:0]    wdata,
    input  logic                re,
    input  logic [AddrBits-1:0] raddr,
    output logic [Width-1:0]    rdata
);

    logic [Width-1:0] mem [DEPTH];

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Synchronous read port; rdata is held between reads.
    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/game_move_history.sv
// Move history LIFO for undo: records accepted moves, replays the newest on undo.
// Latency: move recorded in 1 cycle (step_inc next cycle); undo presented 2 cycles after undo_req.
// Backpressure: undo entry held on undo_valid until undo_ready; moves arriving outside IDLE are dropped.
module game_move_history
    import game_pkg::*;
#(
    parameter int DEPTH   = GAME_DEPTH,
    parameter int PtrBits = GAME_PTR_BITS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               move_valid,
    input  logic [1:0]         move_dir,
    input  logic               move_push,
    input  logic               undo_req,
    input  logic               undo_ready,
    output logic               undo_valid,
    output logic [1:0]         undo_dir,
    output logic               undo_push,
    output logic               step_inc,
    output logic               step_dec,
    output logic [PtrBits-1:0] count,
    output logic               empty,
    output logic               full
);

    localparam logic [PtrBits-1:0] LAST_SLOT = PtrBits'(DEPTH - 1);
    localparam logic [PtrBits-1:0] MAX_COUNT = PtrBits'(DEPTH);

    hist_state_t          state, state_nxt;
    logic [PtrBits-1:0]   top;
    logic [PtrBits-1:0]   top_prev;
    logic [PtrBits-1:0]   top_next;
    logic                 do_push;
    logic                 do_pop;
    logic                 rd_en;
    logic [ENTRY_W-1:0]   rd_data;
    logic [ENTRY_W-1:0]   wr_data;

    // Neighbouring slots with wrap at the ends of the ring.
    assign top_prev = (top == '0)        ? LAST_SLOT : top - 1'b1;
    assign top_next = (top == LAST_SLOT) ? '0        : top + 1'b1;

    assign wr_data  = {move_dir, move_push};
    assign empty    = (count == '0);
    assign full     = (count == MAX_COUNT);
    assign step_dec = do_pop;

    // Data outputs are forced to zero whenever no entry is presented, which also
    // hides the unreset RAM contents after power-up.
    assign undo_dir  = undo_valid ? rd_data[2:1] : 2'b00;
    assign undo_push = undo_valid ? rd_data[0]   : 1'b0;

    // Next-state and handshake decode; a move beats an undo in IDLE, clear beats everything.
    always_comb begin
        state_nxt  = state;
        do_push    = 1'b0;
        do_pop     = 1'b0;
        rd_en      = 1'b0;
        undo_valid = 1'b0;
        case (state)
            IDLE: begin
                if (move_valid) begin
                    do_push = 1'b1;
                end else if (undo_req && !empty) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                rd_en     = 1'b1;
                state_nxt = PRESENT;
            end
            PRESENT: begin
                undo_valid = 1'b1;
                if (undo_ready) begin
                    do_pop    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (clear) begin
            state_nxt  = IDLE;
            do_push    = 1'b0;
            do_pop     = 1'b0;
            undo_valid = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Pointer, occupancy and step_inc pulse; a push when full overwrites the oldest slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top      <= '0;
            count    <= '0;
            step_inc <= 1'b0;
        end else if (clear) begin
            top      <= '0;
            count    <= '0;
            step_inc <= 1'b0;
        end else begin
            step_inc <= do_push;
            if (do_push) begin
                top <= top_next;
                if (!full) count <= count + 1'b1;
            end else if (do_pop) begin
                top   <= top_prev;
                count <= count - 1'b1;
            end
        end
    end

    game_history_ram #(
        .DEPTH    (DEPTH),
        .AddrBits (PtrBits),
        .Width    (ENTRY_W)
    ) u_ram (
        .clk   (clk),
        .we    (do_push),
        .waddr (top),
        .wdata (wr_data),
        .re    (rd_en),
        .raddr (top_prev),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_game_move_history.sv
// Directed bench for game_move_history with hand-computed expectations.
// Latency: n/a.
// Backpressure: exercises held undo entries via undo_ready.
module tb_game_move_history;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       move_valid;
    logic [1:0] move_dir;
    logic       move_push;
    logic       undo_req;
    logic       undo_ready;
    logic       undo_valid;
    logic [1:0] undo_dir;
    logic       undo_push;
    logic       step_inc;
    logic       step_dec;
    logic [7:0] count;
    logic       empty;
    logic       full;

    int total = 0;
    int bad   = 0;
    int n_inc = 0;
    int n_dec = 0;
    int n_both = 0;

    game_move_history dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .move_valid (move_valid),
        .move_dir   (move_dir),
        .move_push  (move_push),
        .undo_req   (undo_req),
        .undo_ready (undo_ready),
        .undo_valid (undo_valid),
        .undo_dir   (undo_dir),
        .undo_push  (undo_push),
        .step_inc   (step_inc),
        .step_dec   (step_dec),
        .count      (count),
        .empty      (empty),
        .full       (full)
    );

    always #5 clk = ~clk;

    // Tally step pulses as seen by the step counter at each rising edge.
    always @(posedge clk) begin
        if (step_inc) n_inc++;
        if (step_dec) n_dec++;
        if (step_inc && step_dec) n_both++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_count"},      32'(count), 0);
        chk({tag, "_empty"},      32'(empty), 1);
        chk({tag, "_full"},       32'(full), 0);
        chk({tag, "_undo_valid"}, 32'(undo_valid), 0);
        chk({tag, "_undo_data"},  32'({undo_dir, undo_push}), 0);
        chk({tag, "_step_inc"},   32'(step_inc), 0);
        chk({tag, "_step_dec"},   32'(step_dec), 0);
    endtask

    // One accepted move; step_inc must follow on the next cycle.
    task automatic do_push(input logic [1:0] dir, input logic psh, input bit check_inc);
        move_valid = 1'b1;
        move_dir   = dir;
        move_push  = psh;
        tick();
        move_valid = 1'b0;
        if (check_inc) chk("push_step_inc", 32'(step_inc), 1);
    endtask

    // Wait (bounded) for undo_valid with the current undo_req/undo_ready drive.
    task automatic wait_present(output bit ok, output int lat);
        ok  = 1'b0;
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (undo_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
            lat++;
        end
    endtask

    // Full undo handshake with undo_ready held high; checks the presented entry.
    task automatic do_undo(input string tag, input logic [2:0] exp, input int exp_lat);
        bit ok;
        int lat;
        undo_req   = 1'b1;
        undo_ready = 1'b1;
        wait_present(ok, lat);
        if (!ok) begin
            chk({tag, "_timeout"}, 0, 1);
        end else begin
            chk({tag, "_data"}, 32'({undo_dir, undo_push}), 32'(exp));
            chk({tag, "_step_dec"}, 32'(step_dec), 1);
            if (exp_lat >= 0) chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
            tick();
        end
        undo_req   = 1'b0;
        undo_ready = 1'b0;
    endtask

    initial begin
        bit ok;
        int lat;
        int inc0;
        int dec0;

        rst_n      = 1'b0;
        clear      = 1'b0;
        move_valid = 1'b0;
        move_dir   = 2'd0;
        move_push  = 1'b0;
        undo_req   = 1'b0;
        undo_ready = 1'b0;
        #12;
        chk_reset_vals("reset");
        rst_n = 1'b1;
        tick();

        // Two moves, two undos: newest first.
        dec0 = n_dec;
        do_push(2'd3, 1'b1, 1'b1);
        do_push(2'd2, 1'b0, 1'b1);
        chk("two_count", 32'(count), 2);
        do_undo("undo_left", 3'b100, 2);
        chk("one_count", 32'(count), 1);
        do_undo("undo_right", 3'b111, 2);
        chk("zero_count", 32'(count), 0);
        chk("zero_empty", 32'(empty), 1);
        chk("two_decs", 32'(n_dec - dec0), 2);

        // Undo on empty history is ignored.
        dec0 = n_dec;
        undo_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("empty_undo_valid", 32'(undo_valid), 0);
        end
        undo_req = 1'b0;
        chk("empty_undo_no_dec", 32'(n_dec - dec0), 0);

        // Move and undo on the same cycle: move wins, undo then returns it.
        do_push(2'd0, 1'b0, 1'b0);
        do_push(2'd1, 1'b1, 1'b0);
        do_push(2'd2, 1'b1, 1'b0);
        chk("three_count", 32'(count), 3);
        move_valid = 1'b1;
        move_dir   = 2'd3;
        move_push  = 1'b0;
        undo_req   = 1'b1;
        undo_ready = 1'b1;
        tick();
        move_valid = 1'b0;
        chk("collide_count", 32'(count), 4);
        chk("collide_step_inc", 32'(step_inc), 1);
        do_undo("collide_undo", 3'b110, 2);
        chk("collide_after", 32'(count), 3);

        // Held presentation: data stable, moves dropped, count unchanged.
        undo_req   = 1'b1;
        undo_ready = 1'b0;
        wait_present(ok, lat);
        undo_req = 1'b0;
        if (!ok) chk("hold_timeout", 0, 1);
        inc0 = n_inc;
        for (int i = 0; i < 5; i++) begin
            move_valid = 1'b1;
            move_dir   = 2'd0;
            move_push  = 1'b0;
            #1;
            chk("hold_valid", 32'(undo_valid), 1);
            chk("hold_data", 32'({undo_dir, undo_push}), 32'(3'b101));
            chk("hold_count", 32'(count), 3);
            chk("hold_no_dec", 32'(step_dec), 0);
            tick();
        end
        move_valid = 1'b0;
        chk("hold_no_inc", 32'(n_inc - inc0), 0);
        undo_ready = 1'b1;
        #1;
        chk("hold_release_dec", 32'(step_dec), 1);
        tick();
        undo_ready = 1'b0;
        chk("hold_release_count", 32'(count), 2);

        // Reset during READ aborts the undo silently.
        dec0 = n_dec;
        undo_req   = 1'b1;
        undo_ready = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rst_in_read");
        undo_req   = 1'b0;
        undo_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_in_read_no_dec", 32'(n_dec - dec0), 0);

        // Clear during PRESENT aborts the undo silently.
        do_push(2'd1, 1'b0, 1'b0);
        do_push(2'd3, 1'b1, 1'b0);
        undo_req   = 1'b1;
        undo_ready = 1'b0;
        wait_present(ok, lat);
        if (!ok) chk("clr_timeout", 0, 1);
        dec0 = n_dec;
        clear      = 1'b1;
        undo_ready = 1'b1;
        #1;
        chk("clr_comb_dec", 32'(step_dec), 0);
        chk("clr_comb_valid", 32'(undo_valid), 0);
        tick();
        clear      = 1'b0;
        undo_req   = 1'b0;
        undo_ready = 1'b0;
        tick();
        chk_reset_vals("clr_in_present");
        chk("clr_no_dec", 32'(n_dec - dec0), 0);

        // Overflow: 256 pushes into 255 slots keep the newest 255.
        inc0 = n_inc;
        for (int i = 0; i < 256; i++) begin
            do_push(2'(i % 4), 1'((i / 4) % 2), 1'b0);
        end
        tick();
        chk("ovf_incs", 32'(n_inc - inc0), 256);
        chk("ovf_full", 32'(full), 1);
        chk("ovf_count", 32'(count), 255);
        dec0 = n_dec;
        for (int k = 0; k < 255; k++) begin
            int idx;
            idx = 255 - k;
            do_undo("ovf_undo", {2'(idx % 4), 1'((idx / 4) % 2)}, -1);
        end
        chk("ovf_decs", 32'(n_dec - dec0), 255);
        chk("ovf_drained", 32'(count), 0);
        chk("ovf_empty", 32'(empty), 1);
        dec0 = n_dec;
        undo_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("ovf_extra_valid", 32'(undo_valid), 0);
        end
        undo_req = 1'b0;
        chk("ovf_extra_no_dec", 32'(n_dec - dec0), 0);

        chk("never_both_steps", 32'(n_both), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
